cm_ucie_d2d_tx_alsm_core: RTL and testbench
===========================================

// Module: cm_ucie_d2d_tx_alsm_core
// PURPOSE
//  Transmit-side Adapter Link State Machine (ALSM) core of the UCIe D2D adapter.
//  - Drives Adapter bring-up once RDI reaches Active.
//  - Sends LinkMgmt Req.Active over the sideband and waits for the remote Rsp.Active.
//  - Reports FDI Active only when the remote Rsp.Active has arrived AND the RX ALSM core has sent our Rsp.Active.
//  - Sits beside the RX ALSM core, between RDI status and the sideband TX/RX message paths.
// PARAMETERS
//  TIMEOUT_CYCLES  1024  cycles allowed in WAIT_RSP before a retry; range >= 2
//  MAX_RETRY       3     number of Req.Active resends after the first send; range >= 0
//  CNT_W           $clog2(TIMEOUT_CYCLES)  width of the timeout counter (derived, localparam)
// PORTS
//  clk_i            in   1  core clock
//  rst_i            in   1  synchronous, active-high reset
//  swrst_i          in   1  software reset; synchronous; same effect as rst_i
//  rdi_state_sts_i  in   4  RDI state: 0000 Reset, 0001 Active, 1010 LinkError
//  state_sts_o      out  4  FDI state, same encoding as rdi_state_sts_i
//  bringup_start_o  out  1  1-cycle pulse that starts Adapter bring-up
//  bringup_done_i   in   1  1-cycle pulse: bring-up complete
//  sb_req_valid_o   out  1  sideband message valid
//  sb_req_ready_i   in   1  sideband accepts the message
//  sb_req_msg_o     out  8  message code; 8'h01 = Req.Active; 8'h00 when not valid
//  sb_rsp_valid_i   in   1  1-cycle pulse: remote Rsp.Active received
//  rx_rsp_sent_i    in   1  level from RX ALSM core: our Rsp.Active has been sent
//  timeout_err_o    out  1  sticky; set on entry to LINKERROR caused by retry exhaustion
// BEHAVIOUR
//  Reset values
//  - On rst_i or swrst_i: state=RESET, state_sts_o=0000, all pulse/valid outputs 0, sb_req_msg_o=00.
//  - Counters and rsp_seen are 0; timeout_err_o=0.
//  States (all outputs registered)
//  - RESET: when rdi_state_sts_i==0001 -> BRINGUP. bringup_start_o=1 in the first BRINGUP cycle only.
//  - BRINGUP: wait for bringup_done_i. On done -> REQ_SEND, with retry count = 0.
//  - REQ_SEND: sb_req_valid_o=1 and msg=01 until sampled sb_req_ready_i=1.
//    Valid stays stable while ready=0. The cycle after the handshake: valid=0, state -> WAIT_RSP, timer = 0.
//  - WAIT_RSP: the timer increments every cycle.
//    If rsp_seen && rx_rsp_sent_i -> ACTIVE; state_sts_o=0001 on the next edge.
//    Else, when timer reaches TIMEOUT_CYCLES-1:
//      - retry<MAX_RETRY: retry++ and -> REQ_SEND (resend).
//      - otherwise: -> LINKERROR and timeout_err_o=1.
//  - ACTIVE: if rdi_state_sts_i==0000 -> RESET. Any other non-0001 value, except 1010, also -> RESET.
//  - LINKERROR: state_sts_o=1010. Exit only when rdi_state_sts_i==0000 -> RESET.
//    timeout_err_o stays set until rst_i or swrst_i.
//  rsp_seen
//  - Set by sb_rsp_valid_i in REQ_SEND or WAIT_RSP; an early Rsp arriving before the handshake is kept.
//  - Cleared in RESET.
//  - Not cleared by a resend.
//  - Ignored in all other states.
//  Simultaneous and global events
//  - Handshake and sb_rsp_valid_i in the same cycle: rsp_seen is set and the state goes to WAIT_RSP.
//  - Success and timeout in the same cycle: success wins.
//  - rdi_state_sts_i==1010 in any state: LINKERROR next cycle (priority over everything but reset).
//  - rdi_state_sts_i==0000 in BRINGUP, REQ_SEND or WAIT_RSP: abort to RESET; valid drops immediately.
//  state_sts_o is 0000 in RESET, BRINGUP, REQ_SEND and WAIT_RSP.
// STRUCTURE
//  - Package cm_ucie_d2d_pkg holds the FDI/RDI state constants (RESET, ACTIVE, LINKERROR).
//  - The same package holds the sideband message codes (REQ_ACTIVE=8'h01) and the alsm_state_e enum, shared with the RX core.
//  - Sub-module cm_ucie_d2d_alsm_timer: timeout counter plus retry counter, with inputs clear/enable and outputs expire/exhausted.
// TESTING
//  1. Nominal: RDI 0001; done 5 cycles after start; ready on the first valid; Rsp 10 cycles later; rx_rsp_sent=1
//     -> state_sts_o=0001 one cycle after the Rsp.
//  2. Backpressure: ready held 0 for 7 cycles -> valid/msg stable at 1/01 all 7 cycles; exactly one accept.
//  3. Early Rsp: Rsp pulse while valid=1 and ready=0 -> after the handshake and rx_rsp_sent=1, ACTIVE with no timeout.
//  4. Timeout: TIMEOUT_CYCLES=16, MAX_RETRY=2, no Rsp -> 3 sends; LINKERROR at 1010 with timeout_err_o=1;
//     RDI 0000 -> RESET with timeout_err_o still 1.
//  5. Abort: RDI 0000 in WAIT_RSP -> RESET next cycle; valid=0; a second bring-up pulses bringup_start_o once.
//  6. RDI 1010 while ACTIVE -> state_sts_o=1010; swrst_i pulse -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/cm_ucie_d2d_pkg.sv
// Shared UCIe D2D adapter definitions: FDI/RDI state codes, sideband message codes
// and the ALSM state enum used by both the TX and RX ALSM cores.
package cm_ucie_d2d_pkg;

  localparam logic [3:0] STS_RESET     = 4'b0000;
  localparam logic [3:0] STS_ACTIVE    = 4'b0001;
  localparam logic [3:0] STS_LINKERROR = 4'b1010;

  localparam logic [7:0] MSG_NONE       = 8'h00;
  localparam logic [7:0] MSG_REQ_ACTIVE = 8'h01;

  typedef enum logic [2:0] {
    StReset,
    StBringup,
    StReqSend,
    StWaitRsp,
    StActive,
    StLinkError
  } alsm_state_e;

  // FDI status reported for a given ALSM state; every bring-up phase reads as Reset.
  function automatic logic [3:0] fdi_sts(input alsm_state_e s);
    case (s)
      StActive:    return STS_ACTIVE;
      StLinkError: return STS_LINKERROR;
      default:     return STS_RESET;
    endcase
  endfunction

endpackage

// File: rtl/cm_ucie_d2d_alsm_timer.sv
// Response timeout counter and Req.Active retry counter for the TX ALSM.
module cm_ucie_d2d_alsm_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tmr_clr_i,
  input  logic tmr_en_i,
  input  logic rty_clr_i,
  input  logic rty_inc_i,
  output logic expire_o,
  output logic exhausted_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  // Retry counter must still be at least one bit wide when no retries are allowed.
  localparam int unsigned RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic [RTY_W-1:0] r_rty;

  // Timeout counter: cleared outside the wait window, counts while enabled.
  always_ff @(posedge clk_i) begin
    if (rst_i || tmr_clr_i) begin
      r_cnt <= '0;
    end else if (tmr_en_i) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Retry counter: survives resends, cleared once the request phase is left.
  always_ff @(posedge clk_i) begin
    if (rst_i || rty_clr_i) begin
      r_rty <= '0;
    end else if (rty_inc_i) begin
      r_rty <= r_rty + RTY_W'(1);
    end
  end

  assign expire_o    = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign exhausted_o = (r_rty >= RTY_W'(MAX_RETRY));

endmodule

// File: rtl/cm_ucie_d2d_tx_alsm_core.sv
// TX Adapter Link State Machine core: bring-up, Req.Active handshake with retry,
// and FDI state reporting.
module cm_ucie_d2d_tx_alsm_core
  import cm_ucie_d2d_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       swrst_i,
  input  logic [3:0] rdi_state_sts_i,
  output logic [3:0] state_sts_o,
  output logic       bringup_start_o,
  input  logic       bringup_done_i,
  output logic       sb_req_valid_o,
  input  logic       sb_req_ready_i,
  output logic [7:0] sb_req_msg_o,
  input  logic       sb_rsp_valid_i,
  input  logic       rx_rsp_sent_i,
  output logic       timeout_err_o
);

  alsm_state_e r_state, w_state_d;
  logic [3:0]  r_sts;
  logic [7:0]  r_msg;
  logic        r_start, r_valid, r_rsp_seen, r_err;
  logic        w_rst, w_rsp_seen, w_in_req, w_err_set;
  logic        w_tmr_clr, w_tmr_en, w_rty_clr, w_rty_inc, w_expire, w_exhausted;

  assign w_rst      = rst_i | swrst_i;
  assign w_in_req   = (r_state == StReqSend) || (r_state == StWaitRsp);
  // A Rsp arriving in the deciding cycle counts, so Active follows the Rsp by one edge.
  assign w_rsp_seen = r_rsp_seen | sb_rsp_valid_i;

  cm_ucie_d2d_alsm_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .MAX_RETRY      (MAX_RETRY)
  ) u_timer (
    .clk_i       (clk_i),
    .rst_i       (w_rst),
    .tmr_clr_i   (w_tmr_clr),
    .tmr_en_i    (w_tmr_en),
    .rty_clr_i   (w_rty_clr),
    .rty_inc_i   (w_rty_inc),
    .expire_o    (w_expire),
    .exhausted_o (w_exhausted)
  );

  // Next-state decode; RDI LinkError, then RDI Reset abort, override the local transitions.
  always_comb begin
    w_state_d = r_state;
    w_tmr_clr = 1'b1;
    w_tmr_en  = 1'b0;
    w_rty_clr = !w_in_req;
    w_rty_inc = 1'b0;
    w_err_set = 1'b0;
    unique case (r_state)
      StReset:   if (rdi_state_sts_i == STS_ACTIVE) w_state_d = StBringup;
      StBringup: if (bringup_done_i) w_state_d = StReqSend;
      StReqSend: if (sb_req_ready_i) w_state_d = StWaitRsp;
      StWaitRsp: begin
        w_tmr_clr = 1'b0;
        w_tmr_en  = 1'b1;
        if (w_rsp_seen && rx_rsp_sent_i) begin
          w_state_d = StActive;
        end else if (w_expire) begin
          if (!w_exhausted) begin
            w_rty_inc = 1'b1;
            w_state_d = StReqSend;
          end else begin
            w_err_set = 1'b1;
            w_state_d = StLinkError;
          end
        end
      end
      StActive: begin
        if (rdi_state_sts_i != STS_ACTIVE && rdi_state_sts_i != STS_LINKERROR) begin
          w_state_d = StReset;
        end
      end
      StLinkError: if (rdi_state_sts_i == STS_RESET) w_state_d = StReset;
      default:     w_state_d = StReset;
    endcase
    if (rdi_state_sts_i == STS_LINKERROR) begin
      w_state_d = StLinkError;
      w_err_set = 1'b0;
      w_rty_inc = 1'b0;
    end else if (rdi_state_sts_i == STS_RESET &&
                 (r_state == StBringup || w_in_req)) begin
      w_state_d = StReset;
      w_err_set = 1'b0;
      w_rty_inc = 1'b0;
    end
  end

  // State register and registered outputs, all derived from the next state.
  always_ff @(posedge clk_i) begin
    if (w_rst) begin
      r_state    <= StReset;
      r_sts      <= STS_RESET;
      r_start    <= 1'b0;
      r_valid    <= 1'b0;
      r_msg      <= MSG_NONE;
      r_rsp_seen <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_sts   <= fdi_sts(w_state_d);
      r_start <= (w_state_d == StBringup) && (r_state == StReset);
      r_valid <= (w_state_d == StReqSend);
      r_msg   <= (w_state_d == StReqSend) ? MSG_REQ_ACTIVE : MSG_NONE;
      if (r_state == StReset) begin
        r_rsp_seen <= 1'b0;
      end else if (sb_rsp_valid_i && w_in_req) begin
        r_rsp_seen <= 1'b1;
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  assign state_sts_o     = r_sts;
  assign bringup_start_o = r_start;
  assign sb_req_valid_o  = r_valid;
  assign sb_req_msg_o    = r_msg;
  assign timeout_err_o   = r_err;

endmodule

// File: tb/tb_cm_ucie_d2d_tx_alsm_core.sv
// Self-checking bench for the TX ALSM core: directed scenarios plus random traffic,
// every cycle compared against a phase/deadline reference model.
module tb_cm_ucie_d2d_tx_alsm_core;

  localparam int T  = 16;
  localparam int MR = 2;
  localparam int PH_RESET = 0, PH_BRING = 1, PH_SEND = 2, PH_WAIT = 3, PH_ACTIVE = 4,
                 PH_ERR = 5;

  logic       clk = 1'b0;
  logic       rst, swrst, done, ready, rsp, rx;
  logic [3:0] rdi;
  logic [3:0] sts;
  logic       start, valid, err;
  logic [7:0] msg;

  int n_checks = 0;
  int n_errors = 0;
  int acc_cnt = 0;
  int start_cnt = 0;

  // Reference model: link phase, absolute deadline cycle and number of sends made.
  int m_ph = PH_RESET;
  int m_cyc = 0;
  int m_deadline = 0;
  int m_sends = 0;
  bit m_rsp = 1'b0;
  bit m_err = 1'b0;
  bit m_start = 1'b0;

  always #5 clk = ~clk;

  cm_ucie_d2d_tx_alsm_core #(
    .TIMEOUT_CYCLES (T),
    .MAX_RETRY      (MR)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .swrst_i         (swrst),
    .rdi_state_sts_i (rdi),
    .state_sts_o     (sts),
    .bringup_start_o (start),
    .bringup_done_i  (done),
    .sb_req_valid_o  (valid),
    .sb_req_ready_i  (ready),
    .sb_req_msg_o    (msg),
    .sb_rsp_valid_i  (rsp),
    .rx_rsp_sent_i   (rx),
    .timeout_err_o   (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    int nph;
    if (rst || swrst) begin
      m_ph    = PH_RESET;
      m_rsp   = 1'b0;
      m_err   = 1'b0;
      m_start = 1'b0;
      m_sends = 0;
    end else begin
      nph     = m_ph;
      m_start = 1'b0;
      if (rdi == 4'b1010) begin
        nph = PH_ERR;
      end else if (rdi == 4'b0000 && (m_ph == PH_BRING || m_ph == PH_SEND || m_ph == PH_WAIT)) begin
        nph = PH_RESET;
      end else begin
        case (m_ph)
          PH_RESET: if (rdi == 4'b0001) begin nph = PH_BRING; m_start = 1'b1; end
          PH_BRING: if (done) begin nph = PH_SEND; m_sends = 0; end
          PH_SEND:  if (ready) begin nph = PH_WAIT; m_sends++; m_deadline = m_cyc + T; end
          PH_WAIT: begin
            if ((m_rsp || rsp) && rx) nph = PH_ACTIVE;
            else if (m_cyc == m_deadline) begin
              if (m_sends <= MR) nph = PH_SEND;
              else begin nph = PH_ERR; m_err = 1'b1; end
            end
          end
          PH_ACTIVE: if (rdi != 4'b0001) nph = PH_RESET;
          PH_ERR:    if (rdi == 4'b0000) nph = PH_RESET;
          default:   nph = PH_RESET;
        endcase
      end
      if (m_ph == PH_RESET) m_rsp = 1'b0;
      else if (rsp && (m_ph == PH_SEND || m_ph == PH_WAIT)) m_rsp = 1'b1;
      m_ph = nph;
    end
    m_cyc++;
  endtask

  // One clock: count accepts, advance the model at the edge, compare #1 later.
  task automatic tick();
    logic [3:0] e_sts;
    if (valid === 1'b1 && ready) acc_cnt++;
    @(posedge clk);
    model_step();
    #1;
    if (start === 1'b1) start_cnt++;
    e_sts = (m_ph == PH_ACTIVE) ? 4'h1 : ((m_ph == PH_ERR) ? 4'hA : 4'h0);
    check("sts", 32'(sts), 32'(e_sts));
    check("valid", 32'(valid), 32'(m_ph == PH_SEND));
    check("msg", 32'(msg), (m_ph == PH_SEND) ? 32'h01 : 32'h00);
    check("start", 32'(start), 32'(m_start));
    check("err", 32'(err), 32'(m_err));
  endtask

  task automatic wait_sts(input logic [3:0] want, input int budget, input string tag);
    int n = 0;
    while (sts !== want && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(sts), 32'(want));
  endtask

  task automatic bringup(input int gap);
    rdi = 4'b0001;
    tick();
    repeat (gap) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  initial begin
    rst = 1'b1; swrst = 1'b0; rdi = 4'b0000; done = 1'b0;
    ready = 1'b0; rsp = 1'b0; rx = 1'b0;
    tick();
    tick();
    check("rst_sts", 32'(sts), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_msg", 32'(msg), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    rst = 1'b0;

    // Nominal bring-up and handshake.
    rdi = 4'b0001; rx = 1'b1;
    tick();
    check("t1_start", 32'(start), 32'h1);
    tick();
    check("t1_start_pulse", 32'(start), 32'h0);
    repeat (2) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    check("t1_valid", 32'(valid), 32'h1);
    check("t1_msg", 32'(msg), 32'h01);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("t1_valid_drop", 32'(valid), 32'h0);
    repeat (9) tick();
    rsp = 1'b1;
    tick();
    rsp = 1'b0;
    check("t1_active", 32'(sts), 32'h1);

    // RDI LinkError while active, then software reset.
    rdi = 4'b1010;
    tick();
    check("t6_linkerr", 32'(sts), 32'hA);
    check("t6_no_timeout", 32'(err), 32'h0);
    swrst = 1'b1; rdi = 4'b0000;
    tick();
    swrst = 1'b0;
    check("t6_swrst_sts", 32'(sts), 32'h0);
    check("t6_swrst_err", 32'(err), 32'h0);

    // Backpressure with an early Rsp, then RX-side gating.
    rx = 1'b0;
    bringup(2);
    acc_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      if (i == 3) rsp = 1'b1;
      tick();
      rsp = 1'b0;
      check("t2_valid_hold", 32'(valid), 32'h1);
      check("t2_msg_hold", 32'(msg), 32'h01);
    end
    ready = 1'b1;
    tick();
    tick();
    ready = 1'b0;
    check("t2_one_accept", 32'(acc_cnt), 32'd1);
    repeat (3) tick();
    check("t3_wait_rx", 32'(sts), 32'h0);
    rx = 1'b1;
    tick();
    check("t3_active", 32'(sts), 32'h1);
    check("t3_no_timeout", 32'(err), 32'h0);

    // Timeout with retry exhaustion.
    rdi = 4'b0000;
    tick();
    bringup(1);
    acc_cnt = 0;
    ready = 1'b1;
    wait_sts(4'hA, 200, "t4_linkerror");
    ready = 1'b0;
    check("t4_sends", 32'(acc_cnt), 32'd3);
    check("t4_err", 32'(err), 32'h1);
    rdi = 4'b0000;
    tick();
    check("t4_reset_sts", 32'(sts), 32'h0);
    check("t4_err_sticky", 32'(err), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t4_err_clear", 32'(err), 32'h0);

    // Aborts from REQ_SEND and WAIT_RSP, then a clean second bring-up.
    bringup(1);
    tick();
    rdi = 4'b0000;
    tick();
    check("t5_abort_send", 32'(valid), 32'h0);
    bringup(1);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    repeat (3) tick();
    rdi = 4'b0000;
    tick();
    check("t5_abort_wait", 32'(sts), 32'h0);
    start_cnt = 0;
    rdi = 4'b0001;
    repeat (6) tick();
    check("t5_start_once", 32'(start_cnt), 32'd1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 199);
      if (r < 2) rdi = 4'b0000;
      else if (r < 4) rdi = 4'b1010;
      else if (r < 5) rdi = 4'b0011;
      else rdi = 4'b0001;
      swrst = ($urandom_range(0, 199) == 0);
      done  = ($urandom_range(0, 4) == 0);
      ready = ($urandom_range(0, 1) == 0);
      rsp   = ($urandom_range(0, 9) == 0);
      rx    = ($urandom_range(0, 4) != 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
